// File: rtl/instruction_fetch_unit_pkg.sv
// Shared MIPS pipeline definitions used by the fetch stage: opcodes, fetch
// FSM encodings and the per-edge action chosen by the next-PC selector.
package mips_pkg;

  localparam logic [5:0]  OPC_HALT   = 6'b111111;
  localparam logic [31:0] NOP_WORD   = 32'h0;
  localparam int          WORD_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH_RUN    = 2'd0,
    FETCH_DRAIN  = 2'd1,
    FETCH_HALTED = 2'd2
  } fetch_state_e;

  localparam logic [1:0] ST_RUN    = FETCH_RUN;
  localparam logic [1:0] ST_DRAIN  = FETCH_DRAIN;
  localparam logic [1:0] ST_HALTED = FETCH_HALTED;

  // What the fetch stage does on the coming edge, decided by pc_next_sel.
  typedef enum logic [2:0] {
    ACT_IDLE        = 3'd0,
    ACT_ADVANCE     = 3'd1,
    ACT_BRANCH      = 3'd2,
    ACT_FLUSH       = 3'd3,
    ACT_HOLD        = 3'd4,
    ACT_HALT        = 3'd5,
    ACT_DRAIN_COUNT = 3'd6,
    ACT_DRAIN_HOLD  = 3'd7
  } fetch_act_e;

  function automatic logic is_halt_word(input logic [31:0] instr);
    return instr[31:26] == OPC_HALT;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-memory port and the
// IF/ID pipeline register outputs. master is the fetch unit itself.
interface instruction_fetch_unit_if;

  logic        Stall;
  logic        Flush;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] IMemAddress;
  logic [31:0] IMemInstruction;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic        Halted;

  modport master (
    input  Stall, Flush, BranchTaken, BranchTarget, IMemInstruction,
    output IMemAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, Halted
  );

  modport slave (
    output Stall, Flush, BranchTaken, BranchTarget, IMemInstruction,
    input  IMemAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, Halted
  );

endinterface

// File: rtl/instruction_fetch_unit_pc_next_sel.sv
// Combinational next-PC and action priority mux for the fetch stage.
// Branch beats flush beats stall beats halt detection beats increment.
module pc_next_sel
  import mips_pkg::*;
(
  input  logic [1:0]  state,
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic        stall,
  input  logic        halt_cond,
  output logic [31:0] pc_next,
  output logic [31:0] pc_plus4,
  output fetch_act_e  act
);

  logic [31:0] target_aligned;
  logic        unused_tgt_bits;

  assign target_aligned  = {branch_target[31:2], 2'b00};
  assign unused_tgt_bits = ^branch_target[1:0];
  assign pc_plus4        = pc + 32'(WORD_BYTES);

  always_comb begin
    pc_next = pc;
    act     = ACT_IDLE;
    case (state)
      ST_RUN: begin
        if (branch_taken) begin
          pc_next = target_aligned;
          act     = ACT_BRANCH;
        end else if (flush) begin
          act = ACT_FLUSH;
        end else if (stall) begin
          act = ACT_HOLD;
        end else if (halt_cond) begin
          act = ACT_HALT;
        end else begin
          pc_next = pc_plus4;
          act     = ACT_ADVANCE;
        end
      end
      // A redirect while draining means the halt word was on a wrong path.
      ST_DRAIN: begin
        if (branch_taken) begin
          pc_next = target_aligned;
          act     = ACT_BRANCH;
        end else if (stall) begin
          act = ACT_DRAIN_HOLD;
        end else begin
          act = ACT_DRAIN_COUNT;
        end
      end
      default: begin
        pc_next = pc;
        act     = ACT_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS instruction fetch stage: owns the PC, captures the fetched word into
// IF/ID, and drains the pipeline after a halt word before raising Halted.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_WORDS   = 128,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic                      Clk,
  input  logic                      Rst,
  instruction_fetch_unit_if.master  bus
);

  localparam int CNT_W = ($clog2(DRAIN_CYCLES) < 3) ? 3 : $clog2(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [29:0]      IMEM_LIMIT = 30'(IMEM_WORDS);

  logic [31:0]      pc_reg, pc_next, pc_plus4;
  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      ifid_instr_reg, ifid_instr_next;
  logic [31:0]      ifid_pc4_reg, ifid_pc4_next;
  logic             ifid_valid_reg, ifid_valid_next;
  logic             halted_reg, halted_next;
  logic             halt_cond;
  fetch_act_e       act;

  // Fetching past the end of memory behaves exactly like hitting a pad word.
  assign halt_cond = is_halt_word(bus.IMemInstruction) || (pc_reg[31:2] >= IMEM_LIMIT);

  pc_next_sel u_pc_next_sel (
    .state         (state_reg),
    .pc            (pc_reg),
    .branch_taken  (bus.BranchTaken),
    .branch_target (bus.BranchTarget),
    .flush         (bus.Flush),
    .stall         (bus.Stall),
    .halt_cond     (halt_cond),
    .pc_next       (pc_next),
    .pc_plus4      (pc_plus4),
    .act           (act)
  );

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    ifid_instr_next = ifid_instr_reg;
    ifid_pc4_next   = ifid_pc4_reg;
    ifid_valid_next = ifid_valid_reg;
    halted_next     = halted_reg;
    case (act)
      ACT_ADVANCE: begin
        ifid_instr_next = bus.IMemInstruction;
        ifid_pc4_next   = pc_plus4;
        ifid_valid_next = 1'b1;
      end
      ACT_BRANCH, ACT_FLUSH, ACT_HALT: begin
        ifid_instr_next = NOP_WORD;
        ifid_pc4_next   = 32'h0;
        ifid_valid_next = 1'b0;
        if (act == ACT_BRANCH) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else if (act == ACT_HALT) begin
          state_next = ST_DRAIN;
          cnt_next   = '0;
        end
      end
      ACT_DRAIN_COUNT: begin
        if (cnt_reg == DRAIN_LAST) begin
          state_next  = ST_HALTED;
          halted_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = state_reg;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc_reg         <= RESET_PC;
      state_reg      <= ST_RUN;
      cnt_reg        <= '0;
      ifid_instr_reg <= NOP_WORD;
      ifid_pc4_reg   <= 32'h0;
      ifid_valid_reg <= 1'b0;
      halted_reg     <= 1'b0;
    end else begin
      pc_reg         <= pc_next;
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      ifid_instr_reg <= ifid_instr_next;
      ifid_pc4_reg   <= ifid_pc4_next;
      ifid_valid_reg <= ifid_valid_next;
      halted_reg     <= halted_next;
    end
  end

  assign bus.IMemAddress      = pc_reg;
  assign bus.IFID_Instruction = ifid_instr_reg;
  assign bus.IFID_PCPlus4     = ifid_pc4_reg;
  assign bus.IFID_Valid       = ifid_valid_reg;
  assign bus.Halted           = halted_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: drives a word-addressed memory
// model and checks PC, IF/ID and Halted against hand-computed values.
module tb_instruction_fetch_unit;

  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] mem [0:127];
  int n_tests = 0;
  int n_fail  = 0;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC     (32'h0000_0000),
    .IMEM_WORDS   (128),
    .DRAIN_CYCLES (4)
  ) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Out-of-range reads return an ordinary word so only the range check halts.
  assign bus.IMemInstruction = (bus.IMemAddress[31:2] < 30'd128) ?
                               mem[bus.IMemAddress[8:2]] : 32'h2400_0000;

  function automatic logic [31:0] w(input int i);
    return 32'h2400_0000 + 32'(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] e_instr,
                          input logic [31:0] e_pc4, input logic e_valid);
    chk({tag, ".instr"}, bus.IFID_Instruction, e_instr);
    chk({tag, ".pc4"}, bus.IFID_PCPlus4, e_pc4);
    chk({tag, ".valid"}, 32'(bus.IFID_Valid), 32'(e_valid));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    $display("[TB] t=%0t pc=%h ifid_instr=%h ifid_pc4=%h valid=%b halted=%b",
             $time, bus.IMemAddress, bus.IFID_Instruction, bus.IFID_PCPlus4,
             bus.IFID_Valid, bus.Halted);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = w(i);
    mem[7] = HALT_W;
    rst = 1'b1;
    bus.Stall = 1'b0;
    bus.Flush = 1'b0;
    bus.BranchTaken = 1'b0;
    bus.BranchTarget = 32'h0;

    // Reset state
    #2;
    chk("rst.addr", bus.IMemAddress, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);
    chk("rst.halted", 32'(bus.Halted), 32'd0);
    tick();
    rst = 1'b0;

    // Free run into the halt word at index 7
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("run.addr", bus.IMemAddress, 32'(4 * k));
      chk_ifid("run", w(k - 1), 32'(4 * k), 1'b1);
    end
    tick();
    chk("halt.addr", bus.IMemAddress, 32'd28);
    chk_ifid("halt", 32'h0, 32'h0, 1'b0);
    chk("halt.halted", 32'(bus.Halted), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("drain.halted", 32'(bus.Halted), 32'd0);
      chk("drain.addr", bus.IMemAddress, 32'd28);
    end
    tick();
    chk("halted.rise", 32'(bus.Halted), 32'd1);
    chk("halted.addr", bus.IMemAddress, 32'd28);
    chk_ifid("halted", 32'h0, 32'h0, 1'b0);
    bus.BranchTaken = 1'b1;
    bus.BranchTarget = 32'h0;
    bus.Flush = 1'b1;
    tick();
    chk("halted.ign", 32'(bus.Halted), 32'd1);
    chk("halted.ign_addr", bus.IMemAddress, 32'd28);
    bus.BranchTaken = 1'b0;
    bus.Flush = 1'b0;

    // Stall for 3 cycles at PC=8
    mem[7] = w(7);
    pulse_reset();
    chk("rst2.addr", bus.IMemAddress, 32'h0);
    chk("rst2.halted", 32'(bus.Halted), 32'd0);
    tick();
    tick();
    chk("pre_stall.addr", bus.IMemAddress, 32'd8);
    chk_ifid("pre_stall", w(1), 32'd8, 1'b1);
    bus.Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall.addr", bus.IMemAddress, 32'd8);
      chk_ifid("stall", w(1), 32'd8, 1'b1);
    end
    bus.Stall = 1'b0;
    tick();
    chk("resume.addr", bus.IMemAddress, 32'd12);
    chk_ifid("resume", w(2), 32'd12, 1'b1);

    // Taken branch with unaligned target at PC=12
    bus.BranchTaken = 1'b1;
    bus.BranchTarget = 32'h13;
    tick();
    chk("br.addr", bus.IMemAddress, 32'h10);
    chk_ifid("br.bubble", 32'h0, 32'h0, 1'b0);
    bus.BranchTaken = 1'b0;
    tick();
    chk("br.addr2", bus.IMemAddress, 32'h14);
    chk_ifid("br.target", w(4), 32'h14, 1'b1);

    // Branch beats stall; then flush alone at PC=16
    bus.BranchTaken = 1'b1;
    bus.BranchTarget = 32'h10;
    bus.Stall = 1'b1;
    tick();
    chk("brst.addr", bus.IMemAddress, 32'h10);
    chk_ifid("brst", 32'h0, 32'h0, 1'b0);
    bus.BranchTaken = 1'b0;
    bus.Stall = 1'b0;
    bus.Flush = 1'b1;
    tick();
    chk("flush.addr", bus.IMemAddress, 32'h10);
    chk_ifid("flush", 32'h0, 32'h0, 1'b0);
    bus.Flush = 1'b0;
    tick();
    chk("postflush.addr", bus.IMemAddress, 32'h14);
    chk_ifid("postflush", w(4), 32'h14, 1'b1);

    // Halt at word 6 cancelled by a branch on the 2nd drain cycle
    mem[6] = HALT_W;
    tick();
    chk_ifid("pre_h", w(5), 32'h18, 1'b1);
    tick();
    chk("cancel.h_addr", bus.IMemAddress, 32'h18);
    chk_ifid("cancel.h", 32'h0, 32'h0, 1'b0);
    tick();
    chk("cancel.d1", 32'(bus.Halted), 32'd0);
    bus.BranchTaken = 1'b1;
    bus.BranchTarget = 32'h0;
    tick();
    chk("cancel.addr", bus.IMemAddress, 32'h0);
    chk("cancel.halted", 32'(bus.Halted), 32'd0);
    chk("cancel.valid", 32'(bus.IFID_Valid), 32'd0);
    bus.BranchTaken = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("cancel.run_halted", 32'(bus.Halted), 32'd0);
      chk_ifid("cancel.run", w(k - 1), 32'(4 * k), 1'b1);
    end

    // Stall in drain freezes the counter: Halted two edges later
    tick();
    chk_ifid("frz.pre", w(5), 32'd24, 1'b1);
    tick();
    chk("frz.h_addr", bus.IMemAddress, 32'd24);
    bus.Stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("frz.stalled", 32'(bus.Halted), 32'd0);
    end
    bus.Stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("frz.count", 32'(bus.Halted), 32'd0);
    end
    tick();
    chk("frz.halted", 32'(bus.Halted), 32'd1);

    // Async reset mid-drain while stalled, between edges
    pulse_reset();
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_ifid("rd.run", w(k - 1), 32'(4 * k), 1'b1);
    end
    tick();
    chk_ifid("rd.h", 32'h0, 32'h0, 1'b0);
    tick();
    bus.Stall = 1'b1;
    tick();
    chk("rd.drain_addr", bus.IMemAddress, 32'd24);
    #2;
    rst = 1'b1;
    #1;
    chk("rd.addr", bus.IMemAddress, 32'h0);
    chk_ifid("rd.ifid", 32'h0, 32'h0, 1'b0);
    chk("rd.halted", 32'(bus.Halted), 32'd0);
    rst = 1'b0;
    bus.Stall = 1'b0;
    tick();
    chk("rd.first_addr", bus.IMemAddress, 32'd4);
    chk_ifid("rd.first", w(0), 32'd4, 1'b1);

    // Last in-range word, then the first out-of-range index halts
    mem[6] = w(6);
    pulse_reset();
    bus.BranchTaken = 1'b1;
    bus.BranchTarget = 32'h1FC;
    tick();
    chk("edge.addr", bus.IMemAddress, 32'h1FC);
    bus.BranchTaken = 1'b0;
    tick();
    chk("edge.addr2", bus.IMemAddress, 32'h200);
    chk_ifid("edge.last", w(127), 32'h200, 1'b1);
    tick();
    chk("edge.oor_addr", bus.IMemAddress, 32'h200);
    chk_ifid("edge.oor", 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("edge.drain", 32'(bus.Halted), 32'd0);
    end
    tick();
    chk("edge.halted", 32'(bus.Halted), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage for the single-issue MIPS pipeline. It owns the program counter and drives the word address into the combinational, read-only instruction memory. It captures the returned word into the IF/ID pipeline register. It also handles stalls, flushes, taken branches/jumps and the halt word (opcode 6'b111111) that pads unused memory, draining the pipeline before asserting `Halted`.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `IMEM_WORDS`, 128, instruction memory depth in words; a PC word index ≥ `IMEM_WORDS` is treated as a halt word
- `DRAIN_CYCLES`, 4, cycles between halt detection and `Halted` assertion (lets older instructions retire)
- `Clk`  in  1  sole clock, rising edge
- `Rst`  in  1  reset, asynchronous, active-high
- `Stall`  in  1  hazard unit: hold PC and IF/ID
- `Flush`  in  1  discard the current fetch; PC is not advanced
- `BranchTaken`  in  1  redirect PC to `BranchTarget`
- `BranchTarget`  in  32  redirect address; bits [1:0] ignored (forced to 0)
- `IMemAddress`  out  32  byte address to instruction memory, = PC
- `IMemInstruction`  in  32  word returned combinationally for `IMemAddress`
- `IFID_Instruction`  out  32  registered instruction; 32'h0 (nop) when not valid
- `IFID_PCPlus4`  out  32  registered PC+4 of that instruction
- `IFID_Valid`  out  1  IF/ID holds a real instruction
- `Halted`  out  1  fetch permanently stopped until reset

## Operation
- States: RUN, DRAIN, HALTED. A 3-bit+ drain counter sized for `DRAIN_CYCLES`.
- The halt condition is `IMemInstruction[31:26]==6'b111111` or `PC[31:2] >= IMEM_WORDS`.
- RUN, per-edge priority (highest first):
  - `BranchTaken`: PC <= {BranchTarget[31:2],2'b00}; IF/ID <= bubble (instr 0, valid 0, PCPlus4 0).
  - `Flush`: PC held; IF/ID <= bubble.
  - `Stall`: PC and IF/ID held.
  - Halt condition: PC held; IF/ID <= bubble; counter <= 0; go to DRAIN.
  - Otherwise: IF/ID <= {IMemInstruction, PC+4, valid 1}; PC <= PC+4.
- DRAIN:
  - PC held; IF/ID is a bubble.
  - `BranchTaken` cancels the halt (the halt was fetched on a wrong path): PC <= target, counter cleared, go to RUN.
  - `Stall` freezes the counter.
  - Otherwise counter++. When the counter reaches `DRAIN_CYCLES-1`, go to HALTED.
- HALTED:
  - `Halted`=1, IF/ID is a bubble, PC frozen.
  - All inputs are ignored except `Rst`.
- Arithmetic: PC+4 is 32-bit and wraps modulo 2^32 (0xFFFF_FFFC → 0x0000_0000). PC[1:0] is always 0.
- Reset (async, any state, mid-stall or mid-drain): PC=`RESET_PC`, IFID_Instruction=0, IFID_PCPlus4=0, IFID_Valid=0, Halted=0, state RUN, counter 0.

## Timing
- `IMemAddress` is a direct wire from the PC register: valid right after each edge, no comb path from inputs.
- Fetch latency: 1 cycle. The word at PC in cycle n appears on the IF/ID outputs after edge n.
- Redirect: a taken branch sampled at edge n puts the target on `IMemAddress` after edge n. The target's instruction reaches IF/ID after edge n+1. Exactly one bubble.
- Halt: the halt word is on `IMemInstruction` at edge h. `Halted` rises after edge h+`DRAIN_CYCLES` (no stalls).
- All outputs are registered. Reset takes effect without a clock edge.

## Structure
- Shared package `mips_pkg`:
  - `OPC_HALT` = 6'b111111
  - `NOP_WORD` = 32'h0
  - fetch state enum {RUN, DRAIN, HALTED}
  - `WORD_BYTES` = 4
- One sub-module is natural: `pc_next_sel`, the combinational next-PC/priority mux (branch/flush/stall/halt/increment). State, counter and registers stay in the top.

## Test plan
- Reset then free-run with the halt word at index 7:
  - PCs 0,4,…,24 fetched.
  - After the 7th edge: IFID_PCPlus4=28, valid=1.
  - PC sticks at 28; IF/ID bubbles.
  - `Halted`=1 exactly 4 edges after the halt is seen.
- `Stall` held 3 cycles with PC=8: `IMemAddress` stays 8; IFID_PCPlus4 stays 8 with the word-1 instruction; resumes at 12.
- `BranchTaken`, target 32'h13, at PC=12: next `IMemAddress`=32'h10; IFID_Valid=0 for one cycle; then IFID_PCPlus4=32'h14.
- `BranchTaken` and `Stall` together: branch wins. With `Flush` alone at PC=16: bubble, PC stays 16.
- Halt detected, then `BranchTaken` (target 0) on the 2nd DRAIN cycle: `Halted` never asserts; `IMemAddress`=0; fetch resumes.
- `Rst` pulsed mid-DRAIN while stalled, between edges: all outputs return to reset values immediately; the first edge after release fetches `RESET_PC`.
